// File: rtl/rand_lfsr.sv
// Free-running maximal-length Fibonacci LFSR; `random` exposes the low state bits.
// The state register itself drives the output, so the output is registered with no extra latency.
module rand_lfsr #(
  parameter int LFSR_WIDTH = 4,
  parameter int OUT_WIDTH  = 4,
  parameter logic [LFSR_WIDTH-1:0] SEED = LFSR_WIDTH'(1)
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic [OUT_WIDTH-1:0] random
);

  if ((LFSR_WIDTH < 3) || (LFSR_WIDTH > 32)) begin : g_bad_lfsr_width
    $error("rand_lfsr: LFSR_WIDTH must be in 3..32");
  end
  if ((OUT_WIDTH < 1) || (OUT_WIDTH > LFSR_WIDTH)) begin : g_bad_out_width
    $error("rand_lfsr: OUT_WIDTH must be in 1..LFSR_WIDTH");
  end

  // Maximal-length tap masks: bit (t-1) set for each 1-indexed tap t.
  function automatic logic [31:0] tap_mask(input logic [5:0] width);
    logic [31:0] m;
    m = 32'h0000_0000;
    case (width)
      6'd3:    m = 32'h0000_0006;
      6'd4:    m = 32'h0000_000C;
      6'd5:    m = 32'h0000_0014;
      6'd6:    m = 32'h0000_0030;
      6'd7:    m = 32'h0000_0060;
      6'd8:    m = 32'h0000_00B8;
      6'd9:    m = 32'h0000_0110;
      6'd10:   m = 32'h0000_0240;
      6'd11:   m = 32'h0000_0500;
      6'd12:   m = 32'h0000_0829;
      6'd13:   m = 32'h0000_100D;
      6'd14:   m = 32'h0000_2015;
      6'd15:   m = 32'h0000_6000;
      6'd16:   m = 32'h0000_D008;
      6'd17:   m = 32'h0001_2000;
      6'd18:   m = 32'h0002_0400;
      6'd19:   m = 32'h0004_0023;
      6'd20:   m = 32'h0009_0000;
      6'd21:   m = 32'h0014_0000;
      6'd22:   m = 32'h0030_0000;
      6'd23:   m = 32'h0042_0000;
      6'd24:   m = 32'h00E1_0000;
      6'd25:   m = 32'h0120_0000;
      6'd26:   m = 32'h0200_0023;
      6'd27:   m = 32'h0400_0013;
      6'd28:   m = 32'h0900_0000;
      6'd29:   m = 32'h1400_0000;
      6'd30:   m = 32'h2000_0029;
      6'd31:   m = 32'h4800_0000;
      6'd32:   m = 32'h8020_0003;
      default: m = 32'h0000_0000;
    endcase
    return m;
  endfunction

  localparam logic [LFSR_WIDTH-1:0] TAP_MASK = LFSR_WIDTH'(tap_mask(6'(LFSR_WIDTH)));
  localparam logic [LFSR_WIDTH-1:0] ZERO     = {LFSR_WIDTH{1'b0}};
  localparam logic [LFSR_WIDTH-1:0] ONE      = LFSR_WIDTH'(1);
  // A zero seed would lock the register, so it is replaced by one.
  localparam logic [LFSR_WIDTH-1:0] SEED_EFF = (SEED == ZERO) ? ONE : SEED;

  logic [LFSR_WIDTH-1:0] state_r;
  logic [LFSR_WIDTH-1:0] step_s;
  logic                  fb_s;

  // Next value when not in reset; the all-zero state recovers to one.
  always_comb begin
    step_s = state_r;
    fb_s   = ^(state_r & TAP_MASK);
    if (state_r == ZERO) begin
      step_s = ONE;
    end else begin
      step_s = {state_r[LFSR_WIDTH-2:0], fb_s};
    end
  end

  // State register with synchronous seed reload.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= SEED_EFF;
    end else begin
      state_r <= step_s;
    end
  end

  assign random = state_r[OUT_WIDTH-1:0];

endmodule

// File: tb/tb_rand_lfsr.sv
// Scoreboard bench for rand_lfsr: several parameterisations share one clock and reset,
// expectations come from the documented sequence and a tap-list polynomial model.
module tb_rand_lfsr;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  random_def;
  logic [3:0]  random_s11;
  logic [3:0]  random_s0;
  logic [3:0]  random_w8;
  logic [15:0] random_w16;

  int total_cnt = 0;
  int bad_cnt   = 0;

  always #5 clk = ~clk;

  rand_lfsr u_def (.clk(clk), .reset(reset), .random(random_def));
  rand_lfsr #(.LFSR_WIDTH(4), .OUT_WIDTH(4), .SEED(4'b1011)) u_s11 (.clk(clk), .reset(reset), .random(random_s11));
  rand_lfsr #(.LFSR_WIDTH(4), .OUT_WIDTH(4), .SEED(4'b0000)) u_s0 (.clk(clk), .reset(reset), .random(random_s0));
  rand_lfsr #(.LFSR_WIDTH(8), .OUT_WIDTH(4), .SEED(8'h01)) u_w8 (.clk(clk), .reset(reset), .random(random_w8));
  rand_lfsr #(.LFSR_WIDTH(16), .OUT_WIDTH(16), .SEED(16'h0001)) u_w16 (.clk(clk), .reset(reset), .random(random_w16));

  // Documented default 4-bit sequence starting at the value 1.
  logic [3:0] seq [15] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                           4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};

  typedef struct {
    logic [3:0]  d;
    logic [3:0]  s11;
    logic [3:0]  s0;
    logic [3:0]  w8;
    logic [15:0] w16;
  } exp_t;

  exp_t sb_q[$];

  int          idx_d   = 0;
  int          idx_s11 = 0;
  int          idx_s0  = 0;
  logic [31:0] st8     = 32'd1;
  logic [31:0] st16    = 32'd1;

  // Polynomial step from a list of 1-indexed taps.
  function automatic logic [31:0] poly_step(input logic [31:0] s, input int w);
    int   taps [4];
    logic fb;
    logic [31:0] mask;
    if (w == 8) taps = '{8, 6, 5, 4};
    else        taps = '{16, 15, 13, 4};
    fb = 1'b0;
    foreach (taps[k]) fb = fb ^ s[taps[k] - 1];
    mask = (32'd1 << w) - 32'd1;
    return ((s << 1) | {31'd0, fb}) & mask;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock edge of stimulus; the model's expectation is queued before the edge.
  task automatic step(input logic rst, input logic lock);
    exp_t e;
    @(negedge clk);
    reset = rst;
    if (lock) begin
      force u_def.state_r = 4'b0000;
      #1;
      release u_def.state_r;
    end
    if (rst) begin
      idx_d = 0; idx_s11 = 9; idx_s0 = 0; st8 = 32'd1; st16 = 32'd1;
    end else begin
      idx_d   = lock ? 0 : (idx_d + 1) % 15;
      idx_s11 = (idx_s11 + 1) % 15;
      idx_s0  = (idx_s0 + 1) % 15;
      st8     = poly_step(st8, 8);
      st16    = poly_step(st16, 16);
    end
    e.d = seq[idx_d]; e.s11 = seq[idx_s11]; e.s0 = seq[idx_s0];
    e.w8 = st8[3:0]; e.w16 = st16[15:0];
    sb_q.push_back(e);
    @(posedge clk);
  endtask

  // Monitor: the generator presents a new value after every edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("def",  {28'd0, random_def}, {28'd0, e.d});
      check("s1011", {28'd0, random_s11}, {28'd0, e.s11});
      check("seed0", {28'd0, random_s0}, {28'd0, e.s0});
      check("w8",   {28'd0, random_w8}, {28'd0, e.w8});
      check("w16",  {16'd0, random_w16}, {16'd0, e.w16});
    end
  end

  initial begin
    int n;
    bit found;
    step(1'b1, 1'b0);
    repeat (30) step(1'b0, 1'b0);
    // Reset mid-run, then held.
    step(1'b1, 1'b0);
    repeat (7) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    repeat (3) step(1'b1, 1'b0);
    repeat (5) step(1'b0, 1'b0);
    // Lock-up recovery on the default instance.
    step(1'b0, 1'b1);
    repeat (6) step(1'b0, 1'b0);
    repeat (200) step(($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0, 1'b0);
    // Full-state period of the 8-bit generator.
    step(1'b1, 1'b0);
    n = 0;
    found = 1'b0;
    for (int i = 1; (i <= 300) && !found; i++) begin
      step(1'b0, 1'b0);
      #1;
      if (u_w8.state_r == 8'h01) begin
        n = i;
        found = 1'b1;
      end
    end
    check("w8_period", n, 32'd255);
    for (int i = 0; (i < 10) && (sb_q.size() > 0); i++) @(negedge clk);
    total_cnt++;
    if (sb_q.size() > 0) begin
      bad_cnt++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
